bit_serializer: RTL
===================

# bit_serializer

Parallel-to-serial stage that converts WIDTH-bit words into a one-bit-per-cycle stream with a valid/ready word handshake on the input side. It sits directly upstream of the sequence detector FSM. `bit_o` drives the detector's serial `in` input, so the detector sees a gap-free bit stream while words arrive back-to-back.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 1'b0: value driven on `bit_o` when no word is being shifted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_i`  in  WIDTH  parallel word to serialize.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `bit_o`  out  1  serial output bit; feeds the detector's `in`.
- `bit_valid_o`  out  1  `bit_o` carries a payload bit this cycle.
- `last_o`  out  1  current bit is the final bit of the word.
- `busy_o`  out  1  a word is in flight (state S_SHIFT).

## Operation
- States:
  - **S_IDLE:** no word loaded.
  - **S_SHIFT:** word loaded; one bit is presented per cycle.
- Registers:
  - `shreg[WIDTH]` holds the word.
  - `cnt[$clog2(WIDTH)]` counts bits remaining minus 1.
- Accept is `valid_i && ready_o` at a rising edge.
- `ready_o = (state == S_IDLE) || (state == S_SHIFT && cnt == 0)`. It is derived from registers only; there is no combinational path from `valid_i`.
- S_IDLE + accept:
  - `shreg <= data_i`, `cnt <= WIDTH-1`, go to S_SHIFT.
  - Without an accept, stay in S_IDLE.
- S_SHIFT with `cnt != 0`:
  - MSB_FIRST=1: `shreg <= shreg << 1`.
  - MSB_FIRST=0: `shreg <= shreg >> 1`.
  - `cnt <= cnt - 1`.
- S_SHIFT with `cnt == 0`:
  - With an accept: reload `shreg`/`cnt` from `data_i` and stay in S_SHIFT (back-to-back, no bubble).
  - Otherwise: go to S_IDLE.
- `bit_o`:
  - In S_SHIFT: `shreg[WIDTH-1]` (MSB_FIRST=1) or `shreg[0]` (MSB_FIRST=0).
  - In S_IDLE: IDLE_BIT.
- `bit_valid_o = busy_o = (state == S_SHIFT)`.
- `last_o = (state == S_SHIFT && cnt == 0)`.
- `data_i` is sampled only on accept. Changes at any other time are ignored.
- `valid_i` held high while `ready_o` = 0 is not an error. The word stays pending until `ready_o` rises; the upstream source must hold `data_i` stable.

## Timing
- Reset values (while `rst` = 0, asynchronously):
  - state = S_IDLE, `cnt` = 0, `shreg` = 0.
  - `bit_o` = IDLE_BIT, `bit_valid_o` = 0, `last_o` = 0, `busy_o` = 0, `ready_o` = 1.
  - No accept occurs while `rst` = 0.
- Latency: a word accepted at edge N presents its first bit during cycle N→N+1 and its last bit during cycle N+WIDTH-1→N+WIDTH.
- Throughput: one word per WIDTH cycles. With `valid_i` continuously high, `bit_valid_o` stays high with zero gaps.
- `ready_o` is high in S_IDLE and in exactly one S_SHIFT cycle per word (the `last_o` cycle).
- Reset mid-word: the in-flight word is discarded and outputs return to their reset values immediately. After `rst` deasserts, the next accepted word starts with `cnt = WIDTH-1`; no residual bits appear.
- Simultaneous last bit + accept: the last bit of the old word and the first bit of the new word appear on consecutive cycles.

## Structure
- Package `serial_pkg`:
  - `typedef enum logic {S_IDLE, S_SHIFT} ser_state_t`.
  - Default localparams for WIDTH and IDLE_BIT, shared with the top-level that instantiates this block plus the detector.
- No sub-module: a single flat module with one state register, the shift register and the down-counter.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `valid_i` = 1 → `bit_o` = 0, `bit_valid_o` = 0, `busy_o` = 0, `ready_o` = 1; no word accepted.
- Single word, WIDTH=8, MSB_FIRST=1, `data_i` = 8'b1011_0000, one-cycle `valid_i` pulse:
  - `bit_o` = 1,0,1,1,0,0,0,0 on the 8 cycles after accept.
  - `last_o` high only on the 8th bit; `ready_o` low for bits 1–7.
  - Downstream detector `out` pulses after the 4th bit.
- Back-to-back: 8'hA5 then 8'h3C with `valid_i` held high → 16 consecutive valid bits 1010_0101_0011_1100, then `bit_valid_o` = 0 and `bit_o` = IDLE_BIT.
- Pending word: assert `valid_i` with 8'hF0 during bit 3 of the previous word → it is accepted only on that word's `last_o` cycle and shifted with no gap.
- Reset mid-word: 8'hFF, pull `rst` low after 3 bits →
  - `bit_o` drops to 0 immediately.
  - After release, 8'h81 shifts as 1,0,0,0,0,0,0,1.
- LSB-first: MSB_FIRST=0, 8'h0D → `bit_o` = 1,0,1,1,0,0,0,0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared state type and default parameters for the serializer and the
// top level that pairs it with the sequence detector.
package serial_pkg;

   typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

   localparam int   SER_WIDTH    = 8;
   localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts a WIDTH-bit word on a valid/ready
// handshake and presents it one bit per cycle, gap-free across words.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int   WIDTH     = SER_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             bit_o,
   output logic             bit_valid_o,
   output logic             last_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH);

   ser_state_t       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;

   logic             w_cntZero;
   logic             w_shifting;
   logic             w_accept;
   logic             w_headBit;

   assign w_cntZero  = (r_cnt == '0);
   assign w_shifting = (r_state == S_SHIFT);

   // Ready depends on registers only, so valid_i never reaches ready_o.
   assign ready_o  = (r_state == S_IDLE) || (w_shifting && w_cntZero);
   assign w_accept = valid_i && ready_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shreg <= data_i;
                  r_cnt   <= CW'(WIDTH - 1);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (!w_cntZero) begin
                  if (MSB_FIRST) begin
                     r_shreg <= r_shreg << 1;
                  end else begin
                     r_shreg <= r_shreg >> 1;
                  end
                  r_cnt <= r_cnt - CW'(1);
               end else if (w_accept) begin
                  // Reload on the last bit so the next word follows with no bubble.
                  r_shreg <= data_i;
                  r_cnt   <= CW'(WIDTH - 1);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_headBit   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
   assign bit_o       = w_shifting ? w_headBit : IDLE_BIT;
   assign bit_valid_o = w_shifting;
   assign busy_o      = w_shifting;
   assign last_o      = w_shifting && w_cntZero;

endmodule
